// File: rtl/writer_pkg.sv
// Shared types and widths for the output-side byte writer.
// Holds the handshake state encoding and the payload width used by writer and its FIFO.
package writer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } wr_state_t;

  // Pointer width for a power-of-two FIFO, never narrower than one bit
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/writer_sync_fifo.sv
// Small synchronous FIFO with flush, used to queue bytes ahead of the pin handshake.
// Pointers wrap naturally; count is one bit wider than the pointers to tell full from empty.
module sync_fifo
  import writer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/writer.sv
// Output byte writer: queues router byte pulses and presents each byte on the pins
// with a 4-phase request/acknowledge handshake against an asynchronous host.
module writer
  import writer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SYNC_FF = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] out_byte_in,
  input  logic              out_byte_pulse,
  input  logic              flush,
  output logic [BYTE_W-1:0] output_byte,
  output logic              output_request,
  input  logic              output_acknowledge,
  output logic              fifo_full,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [SYNC_FF-1:0] sync_q;
  logic               ack_s;

  wr_state_t          state_q, state_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic               req_q, req_d;
  logic               ovf_q, ovf_d;

  logic               pop;
  logic               push_acc;
  logic [BYTE_W-1:0]  fifo_rd_data;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CW-1:0]      fifo_count;

  // Acknowledge comes from another clock domain; only the last stage is trusted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_FF-2:0], output_acknowledge};
  end

  assign ack_s = sync_q[SYNC_FF-1];

  // Flush beats a coincident push; a full FIFO still accepts if the head is leaving
  assign push_acc = out_byte_pulse && !flush && (!fifo_full_s || pop);

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_acc),
    .pop_i     (pop),
    .flush_i   (flush),
    .wr_data_i (out_byte_in),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count)
  );

  // Handshake sequencing; a high ack seen in IDLE blocks the next request
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s && !ack_s) begin
          pop     = 1'b1;
          byte_d  = fifo_rd_data;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = REQ_HI;
      REQ_HI:  if (ack_s)  state_d = REQ_LO;
      REQ_LO:  if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_d = (state_d == REQ_HI);

  always_comb begin
    ovf_d = ovf_q;
    if (flush)                                     ovf_d = 1'b0;
    else if (out_byte_pulse && fifo_full_s && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
    end
  end

  assign output_byte    = byte_q;
  assign output_request = req_q;
  assign overflow       = ovf_q;
  assign fifo_full      = (fifo_count == CW'(DEPTH));
  assign busy           = !fifo_empty_s || (state_q != IDLE);

endmodule

// File: tb/tb_writer.sv
// Scoreboard bench for writer: stimulus queues expected bytes, a monitor checks each request.
module tb_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] out_byte_in = 8'h00;
  logic       out_byte_pulse = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] output_byte;
  logic       output_request;
  logic       output_acknowledge;
  logic       fifo_full;
  logic       busy;
  logic       overflow;

  logic       host_en = 1'b1;
  logic       host_ack = 1'b0;
  logic       ack_force = 1'b0;
  logic       prev_req = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  assign output_acknowledge = host_ack | ack_force;

  writer #(.DEPTH(4), .SYNC_FF(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .out_byte_in        (out_byte_in),
    .out_byte_pulse     (out_byte_pulse),
    .flush              (flush),
    .output_byte        (output_byte),
    .output_request     (output_request),
    .output_acknowledge (output_acknowledge),
    .fifo_full          (fifo_full),
    .busy               (busy),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  // Host: follows the request level one negedge later while enabled
  initial begin
    forever begin
      @(negedge clk);
      if (host_en) begin
        if (output_request && !host_ack)      host_ack = 1'b1;
        else if (!output_request && host_ack) host_ack = 1'b0;
      end
    end
  end

  // Monitor: every rising request must carry the oldest expected byte
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (output_request && !prev_req) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_request: got byte %02h, want no request", output_byte);
          end else begin
            exp_b = exp_q.pop_front();
            if (output_byte !== exp_b) begin
              errors++;
              $display("FAIL delivered_byte: got %02h, want %02h", output_byte, exp_b);
            end
          end
        end
        prev_req = output_request;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; the pulse is sampled at the next edge
  task automatic send(input logic [7:0] b, input bit expect_it);
    out_byte_in    = b;
    out_byte_pulse = 1'b1;
    if (expect_it) exp_q.push_back(b);
    tick();
    out_byte_pulse = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(!busy && !output_request && !output_acknowledge && exp_q.size() == 0)
           && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%0b req=%0b pending=%0d, want idle", name, busy,
               output_request, exp_q.size());
    end
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (!output_request && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got req=0, want req=1", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_byte", 32'(output_byte), 32'h0);
    chk("rst_req", 32'(output_request), 32'h0);
    chk("rst_full", 32'(fifo_full), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();

    // Single byte and latency
    send(8'hA5, 1'b1);
    chk("t1_req_e1", 32'(output_request), 32'h0);
    tick();
    chk("t1_req_e2", 32'(output_request), 32'h0);
    chk("t1_byte_setup", 32'(output_byte), 32'hA5);
    tick();
    chk("t1_req_e3", 32'(output_request), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    wait_idle("t1", 100);
    chk("t1_busy_end", 32'(busy), 32'h0);
    chk("t1_byte_hold", 32'(output_byte), 32'hA5);

    // Burst of DEPTH bytes
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    wait_idle("t2", 300);
    chk("t2_ovf", 32'(overflow), 32'h0);

    // Overflow with stalled host
    host_en = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b1);
    send(8'h15, 1'b0);
    chk("t3_ovf_set", 32'(overflow), 32'h1);
    chk("t3_full", 32'(fifo_full), 32'h1);
    chk("t3_req", 32'(output_request), 32'h1);
    host_en = 1'b1;
    wait_idle("t3", 400);
    chk("t3_ovf_sticky", 32'(overflow), 32'h1);
    pulse_flush();
    chk("t3_ovf_clr", 32'(overflow), 32'h0);

    // Flush during a handshake
    host_en = 1'b0;
    send(8'hB1, 1'b1);
    send(8'hB2, 1'b1);
    send(8'hB3, 1'b1);
    wait_req("t4", 50);
    pulse_flush();
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    chk("t4_busy_inflight", 32'(busy), 32'h1);
    chk("t4_req_held", 32'(output_request), 32'h1);
    host_en = 1'b1;
    wait_idle("t4", 100);
    repeat (10) tick();
    chk("t4_busy_after", 32'(busy), 32'h0);
    chk("t4_no_req", 32'(output_request), 32'h0);

    // Asynchronous reset in REQ_HI
    host_en = 1'b0;
    send(8'h3C, 1'b1);
    wait_req("t5", 50);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_req_async", 32'(output_request), 32'h0);
    chk("t5_byte_async", 32'(output_byte), 32'h0);
    chk("t5_busy_async", 32'(busy), 32'h0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    host_en = 1'b1;
    repeat (10) tick();
    chk("t5_no_req", 32'(output_request), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);

    // Full FIFO, pop and push in the same cycle
    ack_force = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), 1'b1);
    chk("t6_full", 32'(fifo_full), 32'h1);
    chk("t6_guard_req", 32'(output_request), 32'h0);
    ack_force = 1'b0;
    tick();
    tick();
    send(8'h7E, 1'b1);
    chk("t6_full_kept", 32'(fifo_full), 32'h1);
    chk("t6_no_ovf", 32'(overflow), 32'h0);
    wait_idle("t6", 400);
    chk("t6_ovf_end", 32'(overflow), 32'h0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
